// File: rtl/hpdcache_refill_seq_pkg.sv
// Shared types for the HPDcache refill sequencer: FSM state encoding and the
// per-line metadata captured from the owning MSHR entry.
package hpdcache_refill_seq_pkg;

  localparam int unsigned REFILL_SET_W  = 7;
  localparam int unsigned REFILL_WAY_W  = 2;
  localparam int unsigned REFILL_TAG_W  = 20;
  localparam int unsigned REFILL_WORD_W = 2;
  localparam int unsigned REFILL_TID_W  = 6;
  localparam int unsigned REFILL_SID_W  = 3;

  typedef enum logic [2:0] {
    REFILL_RECV  = 3'd0,
    REFILL_ACK   = 3'd1,
    REFILL_META  = 3'd2,
    REFILL_WRITE = 3'd3,
    REFILL_RSP   = 3'd4
  } refill_state_e;

  typedef struct packed {
    logic [REFILL_SET_W-1:0]  set;
    logic [REFILL_WAY_W-1:0]  way;
    logic [REFILL_TAG_W-1:0]  tag;
    logic [REFILL_WORD_W-1:0] word;
    logic [REFILL_TID_W-1:0]  tid;
    logic [REFILL_SID_W-1:0]  sid;
    logic                     need_rsp;
    logic                     is_prefetch;
    logic                     wback;
  } refill_meta_t;

endpackage

// File: rtl/hpdcache_refill_line_buf.sv
// Cacheline assembly buffer: one register row per memory beat, full-line read
// plus a core-word select for the response path.
module hpdcache_refill_line_buf #(
  parameter int unsigned BeatsPerLine = 4,
  parameter int unsigned MemBeatBits  = 64,
  parameter int unsigned WordBits     = 64,
  parameter int unsigned WordIdxWidth = 2,
  parameter int unsigned BeatIdxWidth = 2
) (
  input  logic                                clk_i,
  input  logic                                i_wr_en,
  input  logic [BeatIdxWidth-1:0]             i_wr_idx,
  input  logic [MemBeatBits-1:0]              i_wr_data,
  input  logic [WordIdxWidth-1:0]             i_word_idx,
  output logic [MemBeatBits*BeatsPerLine-1:0] o_line,
  output logic [WordBits-1:0]                 o_word
);

  logic [MemBeatBits-1:0] r_beats [BeatsPerLine];

  // NOTE: the storage array is deliberately not reset; it is only observed
  // after a complete line has overwritten every row, and the owner gates it.
  always_ff @(posedge clk_i) begin
    if (i_wr_en) r_beats[i_wr_idx] <= i_wr_data;
  end

  always_comb begin
    o_line = '0;
    for (int b = 0; b < int'(BeatsPerLine); b++) begin
      o_line[b*MemBeatBits +: MemBeatBits] = r_beats[b];
    end
  end

  assign o_word = o_line[int'(i_word_idx)*WordBits +: WordBits];

endmodule

// File: rtl/hpdcache_refill_seq.sv
// Refill sequencer: gathers the beats of one missed line, acks the MSHR,
// writes line and directory into the cache, then returns the core response.
module hpdcache_refill_seq
  import hpdcache_refill_seq_pkg::*;
#(
  parameter int unsigned MshrSetWidth = 2,
  parameter int unsigned MshrWayWidth = 1,
  parameter int unsigned MemBeatBits  = 64,
  parameter int unsigned BeatsPerLine = 4,
  parameter int unsigned WordBits     = 64,
  parameter int unsigned SetWidth     = REFILL_SET_W,
  parameter int unsigned WayWidth     = REFILL_WAY_W,
  parameter int unsigned TagWidth     = REFILL_TAG_W,
  parameter int unsigned WordIdxWidth = REFILL_WORD_W,
  parameter int unsigned TidWidth     = REFILL_TID_W,
  parameter int unsigned SidWidth     = REFILL_SID_W
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 mem_rsp_valid_i,
  output logic                                 mem_rsp_ready_o,
  input  logic [MshrWayWidth+MshrSetWidth-1:0] mem_rsp_id_i,
  input  logic [MemBeatBits-1:0]               mem_rsp_data_i,
  input  logic                                 mem_rsp_error_i,
  input  logic                                 mem_rsp_last_i,
  output logic                                 mshr_ack_req_o,
  input  logic                                 mshr_ack_gnt_i,
  output logic                                 mshr_ack_o,
  output logic [MshrSetWidth-1:0]              mshr_ack_set_o,
  output logic [MshrWayWidth-1:0]              mshr_ack_way_o,
  input  logic [TidWidth-1:0]                  mshr_ack_req_id_i,
  input  logic [SidWidth-1:0]                  mshr_ack_src_id_i,
  input  logic [SetWidth-1:0]                  mshr_ack_cache_set_i,
  input  logic [WayWidth-1:0]                  mshr_ack_cache_way_i,
  input  logic [TagWidth-1:0]                  mshr_ack_cache_tag_i,
  input  logic [WordIdxWidth-1:0]              mshr_ack_word_i,
  input  logic                                 mshr_ack_need_rsp_i,
  input  logic                                 mshr_ack_is_prefetch_i,
  input  logic                                 mshr_ack_wback_i,
  output logic                                 cache_wr_valid_o,
  input  logic                                 cache_wr_ready_i,
  output logic [SetWidth-1:0]                  cache_wr_set_o,
  output logic [WayWidth-1:0]                  cache_wr_way_o,
  output logic [TagWidth-1:0]                  cache_wr_tag_o,
  output logic [MemBeatBits*BeatsPerLine-1:0]  cache_wr_data_o,
  output logic                                 cache_wr_tag_valid_o,
  output logic                                 cache_wr_wback_o,
  output logic                                 core_rsp_valid_o,
  input  logic                                 core_rsp_ready_i,
  output logic [TidWidth-1:0]                  core_rsp_tid_o,
  output logic [SidWidth-1:0]                  core_rsp_sid_o,
  output logic [WordBits-1:0]                  core_rsp_data_o,
  output logic                                 core_rsp_error_o
);

  localparam int unsigned IdWidth      = MshrWayWidth + MshrSetWidth;
  localparam int unsigned LineBits     = MemBeatBits * BeatsPerLine;
  localparam int unsigned BeatIdxWidth = (BeatsPerLine > 1) ? $clog2(BeatsPerLine) : 1;
  localparam logic [BeatIdxWidth-1:0] LastBeat = BeatIdxWidth'(BeatsPerLine - 1);

  refill_state_e           r_state, w_state_d;
  logic [BeatIdxWidth-1:0] r_beat_cnt;
  logic [IdWidth-1:0]      r_id;
  logic                    r_error;
  refill_meta_t            r_meta;

  logic                    w_beat_acc, w_last_beat, w_wr_hs, w_rsp_hs, w_want_rsp;
  logic [LineBits-1:0]     w_line;
  logic [WordBits-1:0]     w_word;

  assign w_beat_acc  = mem_rsp_valid_i && (r_state == REFILL_RECV);
  assign w_last_beat = (r_beat_cnt == LastBeat);
  assign w_wr_hs     = (r_state == REFILL_WRITE) && cache_wr_ready_i;
  assign w_rsp_hs    = (r_state == REFILL_RSP) && core_rsp_ready_i;
  assign w_want_rsp  = r_meta.need_rsp && !r_meta.is_prefetch;

  // NOTE: the next state is defaulted before the case so every path assigns
  // it and no latch is inferred.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      REFILL_RECV:  if (w_beat_acc && w_last_beat) w_state_d = REFILL_ACK;
      REFILL_ACK:   if (mshr_ack_gnt_i) w_state_d = REFILL_META;
      REFILL_META:  w_state_d = REFILL_WRITE;
      REFILL_WRITE: if (cache_wr_ready_i) w_state_d = w_want_rsp ? REFILL_RSP : REFILL_RECV;
      REFILL_RSP:   if (core_rsp_ready_i) w_state_d = REFILL_RECV;
      default:      w_state_d = REFILL_RECV;
    endcase
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= REFILL_RECV;
      r_beat_cnt <= '0;
      r_id       <= '0;
      r_error    <= 1'b0;
      r_meta     <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_beat_acc) begin
        r_beat_cnt <= w_last_beat ? '0 : r_beat_cnt + 1'b1;
        if (r_beat_cnt == '0) r_id <= mem_rsp_id_i;
        r_error <= r_error | mem_rsp_error_i;
      end
      if (r_state == REFILL_META) begin
        r_meta <= '{set:         mshr_ack_cache_set_i,
                    way:         mshr_ack_cache_way_i,
                    tag:         mshr_ack_cache_tag_i,
                    word:        mshr_ack_word_i,
                    tid:         mshr_ack_req_id_i,
                    sid:         mshr_ack_src_id_i,
                    need_rsp:    mshr_ack_need_rsp_i,
                    is_prefetch: mshr_ack_is_prefetch_i,
                    wback:       mshr_ack_wback_i};
      end
      // The error flag belongs to one line; drop it whenever the line retires.
      if ((w_wr_hs && !w_want_rsp) || w_rsp_hs) r_error <= 1'b0;
    end
  end

  hpdcache_refill_line_buf #(
    .BeatsPerLine (BeatsPerLine),
    .MemBeatBits  (MemBeatBits),
    .WordBits     (WordBits),
    .WordIdxWidth (WordIdxWidth),
    .BeatIdxWidth (BeatIdxWidth)
  ) u_line_buf (
    .clk_i      (clk_i),
    .i_wr_en    (w_beat_acc),
    .i_wr_idx   (r_beat_cnt),
    .i_wr_data  (mem_rsp_data_i),
    .i_word_idx (r_meta.word),
    .o_line     (w_line),
    .o_word     (w_word)
  );

  assign mem_rsp_ready_o = (r_state == REFILL_RECV);

  assign mshr_ack_req_o = (r_state == REFILL_ACK);
  assign mshr_ack_o     = (r_state == REFILL_ACK) && mshr_ack_gnt_i;
  assign mshr_ack_set_o = r_id[MshrSetWidth-1:0];
  assign mshr_ack_way_o = r_id[IdWidth-1:MshrSetWidth];

  // Buffer contents are unreset, so the data buses are gated to zero when idle.
  assign cache_wr_valid_o     = (r_state == REFILL_WRITE);
  assign cache_wr_set_o       = r_meta.set;
  assign cache_wr_way_o       = r_meta.way;
  assign cache_wr_tag_o       = r_meta.tag;
  assign cache_wr_wback_o     = r_meta.wback;
  assign cache_wr_tag_valid_o = cache_wr_valid_o && !r_error;
  assign cache_wr_data_o      = cache_wr_valid_o ? w_line : '0;

  assign core_rsp_valid_o = (r_state == REFILL_RSP);
  assign core_rsp_tid_o   = r_meta.tid;
  assign core_rsp_sid_o   = r_meta.sid;
  assign core_rsp_error_o = r_error;
  assign core_rsp_data_o  = core_rsp_valid_o ? w_word : '0;

  a_last_on_final_beat: assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_beat_acc |-> (mem_rsp_last_i == w_last_beat));
  a_id_stable_in_line: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (w_beat_acc && (r_beat_cnt != '0)) |-> (mem_rsp_id_i == r_id));
  a_ack_needs_gnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mshr_ack_o |-> mshr_ack_gnt_i);

endmodule

// File: tb/tb_hpdcache_refill_seq.sv
// Self-checking bench for hpdcache_refill_seq: an MSHR slot table and a line
// scoreboard predict every ack, cache write and core response.
module tb_hpdcache_refill_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         mem_valid = 0, mem_err = 0, mem_last = 0;
  logic [2:0]   mem_id = '0;
  logic [63:0]  mem_data = '0;
  logic         gnt = 0, wr_rdy = 0, rsp_rdy = 0;

  logic         mem_rsp_ready_o, mshr_ack_req_o, mshr_ack_o;
  logic [1:0]   mshr_ack_set_o;
  logic [0:0]   mshr_ack_way_o;
  logic         cache_wr_valid_o, cache_wr_tag_valid_o, cache_wr_wback_o;
  logic [6:0]   cache_wr_set_o;
  logic [1:0]   cache_wr_way_o;
  logic [19:0]  cache_wr_tag_o;
  logic [255:0] cache_wr_data_o;
  logic         core_rsp_valid_o, core_rsp_error_o;
  logic [5:0]   core_rsp_tid_o;
  logic [2:0]   core_rsp_sid_o;
  logic [63:0]  core_rsp_data_o;

  // MSHR slot contents, indexed by {way,set}, read back on the ack address.
  logic [6:0]  s_set [8];
  logic [1:0]  s_way [8];
  logic [19:0] s_tag [8];
  logic [1:0]  s_word[8];
  logic [5:0]  s_tid [8];
  logic [2:0]  s_sid [8];
  logic        s_need[8], s_pf[8], s_wb[8];
  logic [2:0]  ack_idx;
  assign ack_idx = {mshr_ack_way_o, mshr_ack_set_o};

  hpdcache_refill_seq dut (
    .clk_i                  (clk),
    .rst_ni                 (rst_n),
    .mem_rsp_valid_i        (mem_valid),
    .mem_rsp_ready_o        (mem_rsp_ready_o),
    .mem_rsp_id_i           (mem_id),
    .mem_rsp_data_i         (mem_data),
    .mem_rsp_error_i        (mem_err),
    .mem_rsp_last_i         (mem_last),
    .mshr_ack_req_o         (mshr_ack_req_o),
    .mshr_ack_gnt_i         (gnt),
    .mshr_ack_o             (mshr_ack_o),
    .mshr_ack_set_o         (mshr_ack_set_o),
    .mshr_ack_way_o         (mshr_ack_way_o),
    .mshr_ack_req_id_i      (s_tid[ack_idx]),
    .mshr_ack_src_id_i      (s_sid[ack_idx]),
    .mshr_ack_cache_set_i   (s_set[ack_idx]),
    .mshr_ack_cache_way_i   (s_way[ack_idx]),
    .mshr_ack_cache_tag_i   (s_tag[ack_idx]),
    .mshr_ack_word_i        (s_word[ack_idx]),
    .mshr_ack_need_rsp_i    (s_need[ack_idx]),
    .mshr_ack_is_prefetch_i (s_pf[ack_idx]),
    .mshr_ack_wback_i       (s_wb[ack_idx]),
    .cache_wr_valid_o       (cache_wr_valid_o),
    .cache_wr_ready_i       (wr_rdy),
    .cache_wr_set_o         (cache_wr_set_o),
    .cache_wr_way_o         (cache_wr_way_o),
    .cache_wr_tag_o         (cache_wr_tag_o),
    .cache_wr_data_o        (cache_wr_data_o),
    .cache_wr_tag_valid_o   (cache_wr_tag_valid_o),
    .cache_wr_wback_o       (cache_wr_wback_o),
    .core_rsp_valid_o       (core_rsp_valid_o),
    .core_rsp_ready_i       (rsp_rdy),
    .core_rsp_tid_o         (core_rsp_tid_o),
    .core_rsp_sid_o         (core_rsp_sid_o),
    .core_rsp_data_o        (core_rsp_data_o),
    .core_rsp_error_o       (core_rsp_error_o)
  );

  typedef struct {
    logic [2:0]   id;
    logic [255:0] line;
    bit           err;
    logic [6:0]   set;
    logic [1:0]   way;
    logic [19:0]  tag;
    logic [1:0]   word;
    logic [5:0]   tid;
    logic [2:0]   sid;
    bit           need, pf, wb;
    int           last_cyc;
    bit           timed;
  } line_t;

  line_t exp_q[$];
  line_t rsp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_rsp_done = 0;
  int bp_mode = 0;  // 0: all ready, 1: random, 2: driven by the test

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic finish_now(input string tag);
    check(tag, 256'd0, 256'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  task automatic randomize_slot(input int i);
    s_set[i] = 7'($urandom);  s_way[i] = 2'($urandom); s_tag[i] = 20'($urandom);
    s_word[i] = 2'($urandom); s_tid[i] = 6'($urandom); s_sid[i] = 3'($urandom);
    s_need[i] = ($urandom_range(0, 3) != 0);
    s_pf[i]   = ($urandom_range(0, 3) == 0);
    s_wb[i]   = 1'($urandom);
  endtask

  always @(posedge clk) begin
    #1;
    if (bp_mode == 0) begin
      gnt = 1; wr_rdy = 1; rsp_rdy = 1;
    end else if (bp_mode == 1) begin
      gnt = 1'($urandom); wr_rdy = 1'($urandom); rsp_rdy = 1'($urandom);
    end
  end

  // Called at posedge+1; returns right after the edge that accepted the beat.
  task automatic wait_accept();
    int k = 0;
    while (!mem_rsp_ready_o && k < 500) begin
      @(posedge clk); #1; k++;
    end
    if (k >= 500) finish_now("beat_accept_timeout");
    @(posedge clk); #1;
  endtask

  task automatic send_line(input logic [2:0] id, input logic [255:0] line,
                           input logic [3:0] err_mask, input bit timed,
                           input bit keep_valid, input bit gaps);
    line_t r;
    for (int b = 0; b < 4; b++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        mem_valid = 0;
        repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
      end
      mem_valid = 1; mem_id = id; mem_data = line[b*64 +: 64];
      mem_err = err_mask[b]; mem_last = (b == 3);
      wait_accept();
    end
    if (!keep_valid) mem_valid = 0;
    r.id = id; r.line = line; r.err = |err_mask;
    r.set = s_set[id]; r.way = s_way[id]; r.tag = s_tag[id]; r.word = s_word[id];
    r.tid = s_tid[id]; r.sid = s_sid[id]; r.need = s_need[id]; r.pf = s_pf[id];
    r.wb = s_wb[id]; r.last_cyc = cyc; r.timed = timed;
    exp_q.push_back(r);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((exp_q.size() != 0 || rsp_q.size() != 0 || !mem_rsp_ready_o) && k < 1000) begin
      @(posedge clk); #1; k++;
    end
    if (k >= 1000) finish_now("idle_timeout");
  endtask

  function automatic logic [255:0] pattern_line(input logic [7:0] a, input logic [7:0] b,
                                                input logic [7:0] c, input logic [7:0] d);
    return {{8{d}}, {8{c}}, {8{b}}, {8{a}}};
  endfunction

  // Scoreboard: compares every visible transaction against the predicted line.
  initial begin
    line_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mem_rsp_ready_o)
          check("ready_only_idle", {mshr_ack_req_o, cache_wr_valid_o, core_rsp_valid_o}, 3'b000);
        if (mshr_ack_req_o && !gnt) check("ack_without_gnt", mshr_ack_o, 1'b0);
        if (mshr_ack_o) begin
          if (exp_q.size() == 0) check("ack_unexpected", 1'b1, 1'b0);
          else begin
            e = exp_q[0];
            check("ack_set_way", {mshr_ack_way_o, mshr_ack_set_o}, e.id);
            if (e.timed) check("ack_latency", cyc + 1 - e.last_cyc, 1);
          end
        end
        if (cache_wr_valid_o) begin
          if (exp_q.size() == 0) check("write_unexpected", 1'b1, 1'b0);
          else begin
            e = exp_q[0];
            check("write_meta",
                  {cache_wr_set_o, cache_wr_way_o, cache_wr_tag_o, cache_wr_wback_o, cache_wr_tag_valid_o},
                  {e.set, e.way, e.tag, e.wb, ~e.err});
            check("write_data", cache_wr_data_o, e.line);
            if (wr_rdy) begin
              if (e.timed) check("write_latency", cyc + 1 - e.last_cyc, 3);
              void'(exp_q.pop_front());
              if (e.need && !e.pf) rsp_q.push_back(e);
            end
          end
        end
        if (core_rsp_valid_o) begin
          if (rsp_q.size() == 0) check("rsp_unexpected", 1'b1, 1'b0);
          else begin
            e = rsp_q[0];
            check("rsp_meta", {core_rsp_tid_o, core_rsp_sid_o, core_rsp_error_o}, {e.tid, e.sid, e.err});
            check("rsp_data", core_rsp_data_o, e.line[int'(e.word)*64 +: 64]);
            if (rsp_rdy) begin
              if (e.timed) check("rsp_latency", cyc + 1 - e.last_cyc, 4);
              void'(rsp_q.pop_front());
              n_rsp_done++;
            end
          end
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {mshr_ack_req_o, mshr_ack_o, cache_wr_valid_o, core_rsp_valid_o}, 4'b0);
    check({tag, "_ready"}, mem_rsp_ready_o, 1'b1);
    check({tag, "_idx"}, {mshr_ack_set_o, mshr_ack_way_o, cache_wr_set_o, cache_wr_way_o, cache_wr_tag_o,
                          cache_wr_tag_valid_o, cache_wr_wback_o, core_rsp_tid_o, core_rsp_sid_o,
                          core_rsp_error_o}, '0);
    check({tag, "_wdata"}, cache_wr_data_o, '0);
    check({tag, "_rdata"}, core_rsp_data_o, '0);
  endtask

  initial begin
    int rsp_before;
    logic [255:0] line;
    logic [2:0] id;
    logic [3:0] err;
    for (int i = 0; i < 8; i++) randomize_slot(i);
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    check_reset_outputs("post_reset");

    // Directed line on slot {way1,set2} with minimum latency.
    bp_mode = 0;
    s_need[6] = 1; s_pf[6] = 0; s_word[6] = 2;
    send_line(3'd6, pattern_line(8'h11, 8'h22, 8'h33, 8'h44), 4'b0000, 1, 0, 0);
    wait_idle();

    // Prefetch: cache write but no core response.
    s_pf[6] = 1;
    rsp_before = n_rsp_done;
    send_line(3'd6, pattern_line(8'h11, 8'h22, 8'h33, 8'h44), 4'b0000, 0, 0, 0);
    wait_idle();
    check("prefetch_no_rsp", n_rsp_done, rsp_before);
    check("prefetch_back_to_recv", mem_rsp_ready_o, 1'b1);

    // Error on beat 1, followed by a clean line.
    s_pf[6] = 0;
    send_line(3'd6, pattern_line(8'h55, 8'h66, 8'h77, 8'h88), 4'b0010, 0, 0, 0);
    wait_idle();
    send_line(3'd6, pattern_line(8'h99, 8'haa, 8'hbb, 8'hcc), 4'b0000, 0, 0, 0);
    wait_idle();

    // Grant withheld five cycles, cache write stalled three cycles.
    bp_mode = 2; gnt = 0; wr_rdy = 0; rsp_rdy = 1;
    send_line(3'd6, pattern_line(8'h01, 8'h02, 8'h03, 8'h04), 4'b0000, 0, 0, 0);
    repeat (5) begin
      check("hold_no_ack", {mshr_ack_req_o, mshr_ack_o, mem_rsp_ready_o}, 3'b100);
      @(posedge clk); #1;
    end
    gnt = 1;
    repeat (2) begin @(posedge clk); #1; end
    repeat (3) begin
      check("stall_write", {cache_wr_valid_o, mem_rsp_ready_o}, 2'b10);
      @(posedge clk); #1;
    end
    wr_rdy = 1;
    wait_idle();

    // Back-to-back lines with valid held high across the boundary.
    bp_mode = 0;
    send_line(3'd1, pattern_line(8'hd1, 8'hd2, 8'hd3, 8'hd4), 4'b0000, 0, 1, 0);
    send_line(3'd5, pattern_line(8'he1, 8'he2, 8'he3, 8'he4), 4'b0000, 0, 0, 0);
    wait_idle();

    // Reset in the middle of a line.
    for (int b = 0; b < 2; b++) begin
      mem_valid = 1; mem_id = 3'd3; mem_data = {8{8'hf0 | 8'(b)}}; mem_err = 0; mem_last = 0;
      wait_accept();
    end
    mem_valid = 0;
    rst_n = 0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    repeat (3) begin @(posedge clk); #1; end
    check("mid_reset_no_ack", exp_q.size(), 0);
    send_line(3'd2, pattern_line(8'h5a, 8'h6b, 8'h7c, 8'h8d), 4'b0000, 0, 0, 0);
    wait_idle();

    // Randomised lines under random backpressure.
    bp_mode = 1;
    for (int n = 0; n < 40; n++) begin
      id = 3'($urandom);
      if (exp_q.size() == 0 && rsp_q.size() == 0) randomize_slot(int'(id));
      for (int b = 0; b < 4; b++) line[b*64 +: 64] = {$urandom, $urandom};
      err = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0000;
      send_line(id, line, err, 0, 1'($urandom), 1);
    end
    mem_valid = 0;
    bp_mode = 0;
    wait_idle();
    check("final_queues_empty", exp_q.size() + rsp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    finish_now("global_timeout");
  end

endmodule
